// File: rtl/adc_scan_pkg.sv
// Shared types and helpers for the ADC scan sequencer: FSM state encoding,
// out_data field offsets and channel-mask walking functions.
package adc_scan_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_START  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_STORE  = 3'd4
    } scan_state_t;

    // out_data = {channel, result}; the channel field sits directly above the result.
    localparam int OD_DATA_LSB = 0;

    // Returns {found, index} of the lowest set bit strictly above cur.
    function automatic logic [4:0] next_set_bit(input logic [15:0] mask, input logic [3:0] cur);
        logic [4:0] res;
        res = '0;
        for (int i = 15; i >= 0; i--) begin
            if (i > int'(cur) && mask[i]) res = {1'b1, 4'(i)};
        end
        return res;
    endfunction

    // Index of the lowest set bit; callers guarantee a non-zero mask.
    function automatic logic [3:0] first_set_bit(input logic [15:0] mask);
        logic [3:0] res;
        res = '0;
        for (int i = 15; i >= 0; i--) begin
            if (mask[i]) res = 4'(i);
        end
        return res;
    endfunction

endpackage

// File: rtl/adc_scan_fifo.sv
// Synchronous output FIFO for tagged conversion results; count-based
// full/empty, head entry read straight from the registered storage.
module adc_scan_fifo #(
    parameter int W     = 11,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          do_push, do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    // A push into a full FIFO still lands when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/adc_scan_seq.sv
// Multi-channel SAR ADC scan sequencer with tagged-result output FIFO.
// Define ADC_SCAN_AVG_EN to average 2^AVG_LOG2 conversions per channel.
module adc_scan_seq
    import adc_scan_pkg::*;
#(
    parameter int SIZE       = 8,
    parameter int NCH        = 8,
    parameter int CHW        = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 63
`ifdef ADC_SCAN_AVG_EN
    ,
    parameter int AVG_LOG2   = 2
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                trig,
    input  logic                cont,
    input  logic                stop,
    input  logic [NCH-1:0]      chan_mask,
    input  logic [3:0]          settle,
    output logic                adc_soc,
    input  logic                adc_eoc,
    input  logic [SIZE-1:0]     adc_data,
    output logic [CHW-1:0]      ch_sel,
    output logic                busy,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CHW+SIZE-1:0] out_data,
    output logic                ovr,
    output logic                tmo,
    input  logic                clr_err
);

    localparam int OW        = CHW + SIZE;
    localparam int OD_CH_LSB = OD_DATA_LSB + SIZE;
    localparam int TW        = $clog2(TIMEOUT + 1);

    scan_state_t    state, state_nx;
    logic [NCH-1:0] mask_q, mask_nx;
    logic [CHW-1:0] ch_q, ch_nx;
    logic [3:0]     set_cnt, set_cnt_nx, settle_last;
    logic [TW-1:0]  wait_cnt, wait_cnt_nx;
    logic           stop_q, stop_nx;
    logic           tmo_set, push, pop, drop, fifo_full, fifo_empty;
    logic [SIZE-1:0] result;
    logic [OW-1:0]  push_data;
    logic [4:0]     nxt_hi;
    logic [3:0]     lo_trig, lo_lat;

`ifdef ADC_SCAN_AVG_EN
    localparam int AW = SIZE + AVG_LOG2;
    logic [AW-1:0]       acc_q, acc_nx;
    logic [AVG_LOG2-1:0] avg_cnt, avg_cnt_nx;
    assign result = SIZE'(acc_q >> AVG_LOG2);
`else
    logic [SIZE-1:0] res_q, res_nx;
    assign result = res_q;
`endif

    assign nxt_hi      = next_set_bit(16'(mask_q), 4'(ch_q));
    assign lo_trig     = first_set_bit(16'(chan_mask));
    assign lo_lat      = first_set_bit(16'(mask_q));
    assign settle_last = (settle == 4'd0) ? 4'd0 : settle - 4'd1;

    always_comb begin
        state_nx    = state;
        mask_nx     = mask_q;
        ch_nx       = ch_q;
        set_cnt_nx  = set_cnt;
        wait_cnt_nx = wait_cnt;
        stop_nx     = stop_q | stop;
        tmo_set     = 1'b0;
        push        = 1'b0;
`ifdef ADC_SCAN_AVG_EN
        acc_nx      = acc_q;
        avg_cnt_nx  = avg_cnt;
`else
        res_nx      = res_q;
`endif
        case (state)
            ST_IDLE: begin
                stop_nx = 1'b0;
                if (en && trig && |chan_mask) begin
                    mask_nx    = chan_mask;
                    ch_nx      = CHW'(lo_trig);
                    set_cnt_nx = '0;
                    state_nx   = ST_SETTLE;
`ifdef ADC_SCAN_AVG_EN
                    acc_nx     = '0;
                    avg_cnt_nx = '0;
`endif
                end
            end
            ST_SETTLE: begin
                if (set_cnt >= settle_last) state_nx = ST_START;
                else                        set_cnt_nx = set_cnt + 4'd1;
            end
            ST_START: begin
                wait_cnt_nx = '0;
                state_nx    = ST_WAIT;
            end
            ST_WAIT: begin
                if (adc_eoc) begin
`ifdef ADC_SCAN_AVG_EN
                    acc_nx = acc_q + AW'(adc_data);
                    if (avg_cnt == '1) begin
                        state_nx = ST_STORE;
                    end else begin
                        avg_cnt_nx = avg_cnt + 1'b1;
                        set_cnt_nx = '0;
                        state_nx   = ST_SETTLE;
                    end
`else
                    res_nx   = adc_data;
                    state_nx = ST_STORE;
`endif
                end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                    tmo_set  = 1'b1;
                    state_nx = ST_IDLE;
                end else begin
                    wait_cnt_nx = wait_cnt + TW'(1);
                end
            end
            ST_STORE: begin
                push       = 1'b1;
                set_cnt_nx = '0;
`ifdef ADC_SCAN_AVG_EN
                acc_nx     = '0;
                avg_cnt_nx = '0;
`endif
                // A stop seen anywhere during this channel ends the scan here.
                if (stop_q || stop) begin
                    state_nx = ST_IDLE;
                end else if (nxt_hi[4]) begin
                    ch_nx    = CHW'(nxt_hi[3:0]);
                    state_nx = ST_SETTLE;
                end else if (cont) begin
                    ch_nx    = CHW'(lo_lat);
                    state_nx = ST_SETTLE;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
        // Disable aborts the scan without touching FIFO contents or sticky flags.
        if (!en) begin
            state_nx = ST_IDLE;
            stop_nx  = 1'b0;
            push     = 1'b0;
            tmo_set  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            mask_q   <= '0;
            ch_q     <= '0;
            set_cnt  <= '0;
            wait_cnt <= '0;
            stop_q   <= 1'b0;
            ovr      <= 1'b0;
            tmo      <= 1'b0;
`ifdef ADC_SCAN_AVG_EN
            acc_q    <= '0;
            avg_cnt  <= '0;
`else
            res_q    <= '0;
`endif
        end else begin
            state    <= state_nx;
            mask_q   <= mask_nx;
            ch_q     <= ch_nx;
            set_cnt  <= set_cnt_nx;
            wait_cnt <= wait_cnt_nx;
            stop_q   <= stop_nx;
`ifdef ADC_SCAN_AVG_EN
            acc_q    <= acc_nx;
            avg_cnt  <= avg_cnt_nx;
`else
            res_q    <= res_nx;
`endif
            if (drop)         ovr <= 1'b1;
            else if (clr_err) ovr <= 1'b0;
            if (tmo_set)      tmo <= 1'b1;
            else if (clr_err) tmo <= 1'b0;
        end
    end

    // Output handshake: out_data is stable while out_valid=1; the head entry
    // is consumed on any rising clk edge where out_valid and out_ready are both 1.
    assign pop = out_valid && out_ready;
    assign drop = push && fifo_full && !pop;
    assign push_data[OD_CH_LSB +: CHW]    = ch_q;
    assign push_data[OD_DATA_LSB +: SIZE] = result;

    adc_scan_fifo #(.W(OW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (out_data)
    );

    assign out_valid = !fifo_empty;
    assign adc_soc   = (state == ST_START) && en;
    assign ch_sel    = ch_q;
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_adc_scan_seq.sv
// Self-checking bench for adc_scan_seq: randomized scans against a
// channel-order / FIFO-content reference model, plus directed corner cases.
module tb_adc_scan_seq;

    localparam int SIZE  = 8;
    localparam int NCH   = 8;
    localparam int CHW   = 3;
    localparam int DEPTH = 4;
    localparam int OW    = CHW + SIZE;
`ifdef ADC_SCAN_AVG_EN
    localparam int AVG_LOG2 = 2;
`else
    localparam int AVG_LOG2 = 0;
`endif
    localparam int NAVG = 1 << AVG_LOG2;

    logic            clk, rst_n, en, trig, cont, stop, adc_soc, adc_eoc;
    logic [NCH-1:0]  chan_mask;
    logic [3:0]      settle;
    logic [SIZE-1:0] adc_data;
    logic [CHW-1:0]  ch_sel;
    logic            busy, out_valid, out_ready, ovr, tmo, clr_err;
    logic [OW-1:0]   out_data;

    logic [OW-1:0] exp_q[$];
    bit            exp_ovr;
    int            rdy_mode;   // 0 hold low, 1 random, 2 always high
    int            fixed_base; // <0 random data, else base+k
    int            n_checks, n_errors;

    adc_scan_seq dut (
        .clk(clk), .rst_n(rst_n), .en(en), .trig(trig), .cont(cont), .stop(stop),
        .chan_mask(chan_mask), .settle(settle), .adc_soc(adc_soc), .adc_eoc(adc_eoc),
        .adc_data(adc_data), .ch_sel(ch_sel), .busy(busy), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .ovr(ovr), .tmo(tmo), .clr_err(clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: score the pop about to happen, advance, pick next out_ready.
    task automatic tick();
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("unexpected_entry", {21'd0, out_data}, 32'hdead);
            else                   check("out_data", {21'd0, out_data}, {21'd0, exp_q.pop_front()});
        end
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = (exp_q.size() >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
            default: out_ready = 1'b1;
        endcase
    endtask

    task automatic drain();
        int n;
        rdy_mode = 2;
        n = 0;
        while (exp_q.size() > 0 && n < 60) begin
            tick();
            n++;
        end
        check("drain_done", exp_q.size(), 0);
        tick();
        check("fifo_empty", {31'd0, out_valid}, 0);
    endtask

    task automatic run_scan(input logic [7:0] mask, input logic [3:0] st, input bit c, input int nconv);
        int chans[$];
        int idx, n, lat, sum, gap;
        logic [SIZE-1:0] d;
        logic [OW-1:0]   entry;
        for (int i = 0; i < NCH; i++) if (mask[i]) chans.push_back(i);
        gap = (st == 0) ? 1 : int'(st);
        chan_mask = mask;
        settle    = st;
        cont      = c;
        trig      = 1'b1;
        tick();
        trig = 1'b0;
        idx  = 0;
        for (int k = 0; k < nconv; k++) begin
            sum = 0;
            for (int a = 0; a < NAVG; a++) begin
                n = 0;
                while (!adc_soc && n < 40) begin
                    tick();
                    n++;
                end
                if (!adc_soc) begin
                    check("soc_wait", 0, 1);
                    return;
                end
                check("settle_len", n, gap);
                check("ch_sel", {29'd0, ch_sel}, chans[idx]);
                tick();
                lat = $urandom_range(1, 4);
                repeat (lat - 1) tick();
                d = (fixed_base < 0) ? SIZE'($urandom) : SIZE'(fixed_base + a);
                adc_eoc  = 1'b1;
                adc_data = d;
                if (c && k == nconv - 1 && a == NAVG - 1) stop = 1'b1;
                tick();
                adc_eoc  = 1'b0;
                adc_data = SIZE'($urandom);
                stop     = 1'b0;
                sum += int'(d);
            end
            entry = {CHW'(chans[idx]), SIZE'(sum >> AVG_LOG2)};
            if (rdy_mode == 0 && exp_q.size() == DEPTH) exp_ovr = 1'b1;
            else                                        exp_q.push_back(entry);
            tick();
            check("ovr", {31'd0, ovr}, {31'd0, exp_ovr});
            idx = (idx + 1) % chans.size();
        end
        check("busy_end", {31'd0, busy}, 0);
        cont = 1'b0;
    endtask

    initial begin
        int n;
        bit saw_soc;
        logic [7:0] m;
        n_checks = 0; n_errors = 0;
        rst_n = 1'b0; en = 1'b1; trig = 1'b0; cont = 1'b0; stop = 1'b0;
        chan_mask = '0; settle = '0; adc_eoc = 1'b0; adc_data = '0;
        out_ready = 1'b0; clr_err = 1'b0;
        rdy_mode = 1; fixed_base = -1; exp_ovr = 1'b0;
        #23;
        check("rst_soc",   {31'd0, adc_soc},   0);
        check("rst_chsel", {29'd0, ch_sel},    0);
        check("rst_busy",  {31'd0, busy},      0);
        check("rst_valid", {31'd0, out_valid}, 0);
        check("rst_data",  {21'd0, out_data},  0);
        check("rst_ovr",   {31'd0, ovr},       0);
        check("rst_tmo",   {31'd0, tmo},       0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Channels 0 and 2, settle 2.
        run_scan(8'b0000_0101, 4'd2, 1'b0, 2);
        drain();

        // Zero mask: trigger ignored.
        chan_mask = '0;
        trig = 1'b1;
        tick();
        trig = 1'b0;
        saw_soc = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (adc_soc || busy) saw_soc = 1'b1;
            tick();
        end
        check("zero_mask_idle", {31'd0, saw_soc}, 0);

        // Randomized one-shot and continuous scans.
        for (int r = 0; r < 6; r++) begin
            m = 8'($urandom_range(1, 255));
            run_scan(m, 4'($urandom_range(0, 5)), 1'b0, $countones(m));
            drain();
            rdy_mode = 1;
        end
        for (int r = 0; r < 3; r++) begin
            m = 8'($urandom_range(1, 255));
            run_scan(m, 4'($urandom_range(0, 3)), 1'b1, $countones(m) + 2);
            drain();
            rdy_mode = 1;
        end

        // Overflow with a stalled consumer.
        rdy_mode = 0;
        tick();
        run_scan(8'h80, 4'd1, 1'b1, 6);
        check("ovr_valid", {31'd0, out_valid}, 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        exp_ovr = 1'b0;
        check("ovr_cleared", {31'd0, ovr}, 0);
        drain();

        // Converter never answers.
        chan_mask = 8'h02; settle = 4'd0; trig = 1'b1;
        tick();
        trig = 1'b0;
        n = 0;
        while (!adc_soc && n < 40) begin tick(); n++; end
        check("tmo_soc", {31'd0, adc_soc}, 1);
        n = 0;
        while (busy && n < 100) begin tick(); n++; end
        check("tmo_cycles", n, 64);
        check("tmo_flag", {31'd0, tmo}, 1);
        check("tmo_nopush", {31'd0, out_valid}, 0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("tmo_cleared", {31'd0, tmo}, 0);

        // Disable during WAIT keeps the FIFO and ignores a late eoc.
        rdy_mode = 0;
        tick();
        run_scan(8'h04, 4'd0, 1'b0, 1);
        chan_mask = 8'h01; trig = 1'b1;
        tick();
        trig = 1'b0;
        n = 0;
        while (!adc_soc && n < 40) begin tick(); n++; end
        tick();
        tick();
        en = 1'b0;
        tick();
        check("en_abort_busy", {31'd0, busy}, 0);
        check("en_abort_soc",  {31'd0, adc_soc}, 0);
        en = 1'b1;
        adc_eoc = 1'b1; adc_data = 8'h5a;
        tick();
        adc_eoc = 1'b0;
        tick();
        tick();
        check("late_eoc_busy", {31'd0, busy}, 0);
        drain();

`ifdef ADC_SCAN_AVG_EN
        fixed_base = 10;
        rdy_mode = 0;
        tick();
        run_scan(8'h08, 4'd1, 1'b0, 1);
        check("avg_model", {21'd0, exp_q[0]}, {21'd0, 3'd3, 8'd11});
        drain();
        fixed_base = -1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
